// File: rtl/hazard_if.sv
// ----------------------------------------------------------------------------
// hazard_if
// Purpose : groups the pipeline-side signals exchanged with the hazard
//           controller (IF/ID operand fields, decoded MemRead, branch
//           resolution, and the stall/flush controls plus statistics).
// Modports:
//   master - pipeline side: drives operand fields, ID_MemRead, branchTaken;
//            observes stall/flush controls and counters.
//   slave  - hazard controller side: the reverse directions.
// Parameter CNT_W : width of the stall/flush statistics counters.
// ----------------------------------------------------------------------------
interface hazard_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       IFID_rs;
    logic [4:0]       IFID_rt;
    logic             ID_MemRead;
    logic             branchTaken;
    logic             riskSig;
    logic             PCWrite;
    logic             IFIDWrite;
    logic             IFIDFlush;
    logic             EXFlush;
    logic [CNT_W-1:0] stallCnt;
    logic [CNT_W-1:0] flushCnt;

    modport master (
        output IFID_rs, IFID_rt, ID_MemRead, branchTaken,
        input  riskSig, PCWrite, IFIDWrite, IFIDFlush, EXFlush, stallCnt, flushCnt
    );

    modport slave (
        input  IFID_rs, IFID_rt, ID_MemRead, branchTaken,
        output riskSig, PCWrite, IFIDWrite, IFIDFlush, EXFlush, stallCnt, flushCnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_ctrl
// Purpose : load-use stall and taken-branch flush controller for a 5-stage
//           pipeline, with saturating statistics counters.
// Ports:
//   clk  - pipeline clock, rising-edge active
//   rst  - asynchronous active-high reset
//   hif  - hazard_if.slave:
//            in : IFID_rs, IFID_rt, ID_MemRead, branchTaken
//            out: riskSig, PCWrite, IFIDWrite, IFIDFlush, EXFlush,
//                 stallCnt, flushCnt
// Parameter CNT_W : counter width (must match the interface instance).
// ----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic     clk,
    input  logic     rst,
    hazard_if.slave  hif
);

    typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

    state_t           state_q, state_d;
    logic             ex_memread_q, ex_memread_d;
    logic [4:0]       ex_rt_q, ex_rt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic load_use;
    logic stall;
    logic risk;
    logic pc_wr;
    logic ifid_wr;
    logic flush;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    // rt is compared for every consumer, even ones that only read rs; this
    // costs an occasional spurious stall but avoids decoding the format.
    assign load_use = ex_memread_q && (ex_rt_q != 5'd0) &&
                      ((ex_rt_q == hif.IFID_rs) || (ex_rt_q == hif.IFID_rt));

    always_comb begin
        state_d = RUN;
        stall   = 1'b0;
        risk    = 1'b0;
        pc_wr   = 1'b1;
        ifid_wr = 1'b1;
        flush   = 1'b0;
        // Reset gates everything so the outputs take their idle values
        // immediately, whatever branchTaken happens to be doing.
        if (!rst) begin
            if (hif.branchTaken) begin
                state_d = FLUSH;
                risk    = 1'b1;
                flush   = 1'b1;
            end else if ((state_q == RUN) && load_use) begin
                stall   = 1'b1;
                risk    = 1'b1;
                pc_wr   = 1'b0;
                ifid_wr = 1'b0;
            end
        end
    end

    // A bubble enters ID/EX whenever riskSig is high, which is what makes a
    // load-use stall self-terminating after one cycle.
    always_comb begin
        ex_memread_d = risk ? 1'b0 : hif.ID_MemRead;
        ex_rt_d      = risk ? 5'd0 : hif.IFID_rt;
        stall_cnt_d  = stall ? sat_inc(stall_cnt_q) : stall_cnt_q;
        flush_cnt_d  = hif.branchTaken ? sat_inc(flush_cnt_q) : flush_cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RUN;
            ex_memread_q <= 1'b0;
            ex_rt_q      <= 5'd0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            ex_memread_q <= ex_memread_d;
            ex_rt_q      <= ex_rt_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign hif.riskSig   = risk;
    assign hif.PCWrite   = pc_wr;
    assign hif.IFIDWrite = ifid_wr;
    assign hif.IFIDFlush = flush;
    assign hif.EXFlush   = flush;
    assign hif.stallCnt  = stall_cnt_q;
    assign hif.flushCnt  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_hazard_ctrl
// Purpose : self-checking bench for hazard_ctrl (CNT_W = 4). Expected values
//           come from an instruction-level model: which instruction sits in
//           ID/EX, whether the ID instruction depends on a load there, and
//           saturating integer tallies of stalls and flushes.
// ----------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam int CW  = 4;
    localparam int MAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;

    hazard_if #(.CNT_W(CW)) hif ();

    hazard_ctrl #(.CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .hif (hif)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: the instruction currently occupying ID/EX.
    int idex_is_load = 0;
    int idex_dest    = 0;
    int m_stalls     = 0;
    int m_flushes    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".riskSig"},   32'(hif.riskSig),   32'd0);
        chk({tag, ".PCWrite"},   32'(hif.PCWrite),   32'd1);
        chk({tag, ".IFIDWrite"}, 32'(hif.IFIDWrite), 32'd1);
        chk({tag, ".IFIDFlush"}, 32'(hif.IFIDFlush), 32'd0);
        chk({tag, ".EXFlush"},   32'(hif.EXFlush),   32'd0);
        chk({tag, ".stallCnt"},  32'(hif.stallCnt),  32'd0);
        chk({tag, ".flushCnt"},  32'(hif.flushCnt),  32'd0);
    endtask

    task automatic model_reset();
        idex_is_load = 0;
        idex_dest    = 0;
        m_stalls     = 0;
        m_flushes    = 0;
    endtask

    // One pipeline cycle: drive at the falling edge, check just after, then
    // advance the model across the rising edge.
    task automatic step(input string tag, input int rs, input int rt, input int mr, input int br);
        bit depends, stall_now, bubble;
        @(negedge clk);
        hif.IFID_rs     = 5'(rs);
        hif.IFID_rt     = 5'(rt);
        hif.ID_MemRead  = 1'(mr);
        hif.branchTaken = 1'(br);
        #1;
        depends   = (idex_is_load != 0) && (idex_dest != 0) &&
                    (idex_dest == rs || idex_dest == rt);
        stall_now = depends && (br == 0);
        bubble    = stall_now || (br != 0);
        chk({tag, ".riskSig"},   32'(hif.riskSig),   32'(bubble));
        chk({tag, ".PCWrite"},   32'(hif.PCWrite),   32'(!stall_now));
        chk({tag, ".IFIDWrite"}, 32'(hif.IFIDWrite), 32'(!stall_now));
        chk({tag, ".IFIDFlush"}, 32'(hif.IFIDFlush), 32'(br != 0));
        chk({tag, ".EXFlush"},   32'(hif.EXFlush),   32'(br != 0));
        chk({tag, ".stallCnt"},  32'(hif.stallCnt),  32'(m_stalls));
        chk({tag, ".flushCnt"},  32'(hif.flushCnt),  32'(m_flushes));
        @(posedge clk);
        if (stall_now && m_stalls < MAX) m_stalls++;
        if (br != 0 && m_flushes < MAX)  m_flushes++;
        if (bubble) begin
            idex_is_load = 0;
            idex_dest    = 0;
        end else begin
            idex_is_load = mr;
            idex_dest    = rt;
        end
    endtask

    task automatic chk_counts(input string tag);
        @(negedge clk);
        #1;
        chk({tag, ".stallCnt"}, 32'(hif.stallCnt), 32'(m_stalls));
        chk({tag, ".flushCnt"}, 32'(hif.flushCnt), 32'(m_flushes));
    endtask

    initial begin
        rst             = 1'b1;
        hif.IFID_rs     = 5'd0;
        hif.IFID_rt     = 5'd0;
        hif.ID_MemRead  = 1'b0;
        hif.branchTaken = 1'b1;
        #12;
        chk_idle("reset_hold_branch");
        @(negedge clk);
        hif.branchTaken = 1'b0;
        rst = 1'b0;
        model_reset();

        // Basic load-use: one-cycle stall, then the bubble releases it.
        step("lu_load",    0, 2, 1, 0);
        step("lu_stall",   2, 0, 0, 0);
        step("lu_release", 2, 0, 0, 0);

        // Reset asserted in the middle of a stall cycle.
        step("rs_load", 0, 2, 1, 0);
        @(negedge clk);
        hif.IFID_rs    = 5'd2;
        hif.IFID_rt    = 5'd0;
        hif.ID_MemRead = 1'b0;
        #1;
        chk("rs_pre.riskSig", 32'(hif.riskSig), 32'd1);
        chk("rs_pre.PCWrite", 32'(hif.PCWrite), 32'd0);
        #1 rst = 1'b1;
        #1;
        chk_idle("rs_async");
        @(posedge clk);
        #1;
        chk_idle("rs_clocked");
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Register $0 and unrelated operands never stall.
        step("z_load",   0, 0, 1, 0);
        step("z_use",    0, 0, 0, 0);
        step("ind_load", 0, 3, 1, 0);
        step("ind_use",  4, 5, 0, 0);
        chk_counts("ind_cnt");

        // Branch beats a simultaneous load-use; the next cycle is the flush shadow.
        step("pri_load",   0, 2, 1, 0);
        step("pri_both",   2, 2, 0, 1);
        step("pri_after",  2, 2, 0, 0);

        // Back-to-back taken branches.
        step("bb_br1",  1, 1, 1, 1);
        step("bb_br2",  1, 1, 1, 1);
        step("bb_done", 1, 1, 0, 0);
        chk_counts("bb_cnt");

        // Seventeen stalls saturate a 4-bit counter.
        for (int i = 0; i < 17; i++) begin
            step("sat_load", 0, 2, 1, 0);
            step("sat_use",  2, 0, 0, 0);
        end
        chk_counts("sat_cnt");

        // Random traffic over a small register set so hazards are frequent.
        for (int i = 0; i < 400; i++) begin
            step("rnd",
                 int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0) ? 1 : 0);
        end
        chk_counts("rnd_cnt");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
